// File: rtl/vending_sale_controller.sv
// rtl/vending_sale_controller.sv - coin-credit sale controller; optional inactivity refund via SALE_TIMEOUT_EN
module vending_sale_controller #(
    parameter int PRICE          = 3,
    parameter int CREDIT_W       = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk1,
    input  logic                reset1,
    input  logic                coin1,
    input  logic                coin2,
    input  logic                buy,
    input  logic                cancel,
    input  logic                stock_avail,
    output logic                red_inventario,
    output logic                dispense,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] change_value,
    output logic                change_valid,
    output logic                coin_reject,
    output logic                sold_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_RETURN = 2'd3
    } stateT;

    // Two extra bits so credit plus a double coin (up to +3) never wraps before the overflow test.
    localparam int                  SUM_W   = CREDIT_W + 2;
    localparam logic [SUM_W-1:0]    MAX_SUM = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    stateT               state;
    logic                prevCoin1, prevCoin2, prevBuy, prevCancel;
    logic                coin1Edge, coin2Edge, buyEdge, cancelEdge, coinAny;
    logic [SUM_W-1:0]    coinAdd, creditSum;
    logic                coinFits;
    logic                timedOut;
    logic                coinRejectQ;

    assign coin1Edge  = coin1 & ~prevCoin1;
    assign coin2Edge  = coin2 & ~prevCoin2;
    assign buyEdge    = buy & ~prevBuy;
    assign cancelEdge = cancel & ~prevCancel;
    assign coinAny    = coin1Edge | coin2Edge;

    // coin2 is worth two units, coin1 one, so the edge pair forms the binary addend directly.
    assign coinAdd   = {{(SUM_W-2){1'b0}}, coin2Edge, coin1Edge};
    assign creditSum = {2'b00, credit} + coinAdd;
    assign coinFits  = (creditSum <= MAX_SUM);

`ifdef SALE_TIMEOUT_EN
    localparam int               TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0] idleTimer;

    assign timedOut = (idleTimer == TIMER_LIMIT);

    // Inactivity counter: zero outside CREDIT (so entry starts fresh), cleared by any edge, saturates at the limit.
    always_ff @(posedge clk1) begin
        if (reset1 || state != ST_CREDIT) begin
            idleTimer <= '0;
        end else if (coinAny || buyEdge || cancelEdge) begin
            idleTimer <= '0;
        end else if (!timedOut) begin
            idleTimer <= idleTimer + 1'b1;
        end
    end
`else
    logic unusedTimeoutCfg;

    assign timedOut         = 1'b0;
    assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
`endif

    // Moore pulses decoded from the registered state; refund amount is the credit held in RETURN.
    assign red_inventario = (state == ST_VEND);
    assign dispense       = (state == ST_VEND);
    assign change_valid   = (state == ST_RETURN);
    assign change_value   = (state == ST_RETURN) ? credit : '0;
    assign coin_reject    = coinRejectQ;
    assign sold_out       = ~stock_avail;

    // Sale FSM with input edge history; prev_* track inputs even in reset so held inputs give no edge on release.
    always_ff @(posedge clk1) begin
        prevCoin1  <= coin1;
        prevCoin2  <= coin2;
        prevBuy    <= buy;
        prevCancel <= cancel;
        if (reset1) begin
            state       <= ST_IDLE;
            credit      <= '0;
            coinRejectQ <= 1'b0;
        end else begin
            coinRejectQ <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (coinAny) begin
                        if (coinFits) begin
                            credit <= creditSum[CREDIT_W-1:0];
                            state  <= ST_CREDIT;
                        end else begin
                            coinRejectQ <= 1'b1;
                        end
                    end
                end
                ST_CREDIT: begin
                    if (cancelEdge) begin
                        state <= ST_RETURN;
                    end else if (buyEdge) begin
                        if (!stock_avail) begin
                            state <= ST_RETURN;
                        end else if (credit >= PRICE_C) begin
                            state <= ST_VEND;
                        end
                    end else if (coinAny) begin
                        if (coinFits) begin
                            credit <= creditSum[CREDIT_W-1:0];
                        end else begin
                            coinRejectQ <= 1'b1;
                        end
                    end else if (timedOut) begin
                        state <= ST_RETURN;
                    end
                end
                ST_VEND: begin
                    credit <= credit - PRICE_C;
                    state  <= ST_RETURN;
                end
                ST_RETURN: begin
                    credit <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_sale_controller.sv
// tb/tb_vending_sale_controller.sv - directed self-checking bench for vending_sale_controller
module tb_vending_sale_controller;

    logic       clk1 = 1'b0;
    logic       reset1 = 1'b1;
    logic       coin1 = 1'b0;
    logic       coin2 = 1'b0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    wire        stock_avail;
    logic       red_inventario;
    logic       dispense;
    logic [2:0] credit;
    logic [2:0] change_value;
    logic       change_valid;
    logic       coin_reject;
    logic       sold_out;

    logic       useInv = 1'b0;
    logic       invLoad = 1'b0;
    logic       stockManual = 1'b1;
    logic [1:0] invCount = 2'd0;

    int passCount = 0;
    int totalCount = 0;

    vending_sale_controller #(
        .PRICE(3),
        .CREDIT_W(3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk1(clk1),
        .reset1(reset1),
        .coin1(coin1),
        .coin2(coin2),
        .buy(buy),
        .cancel(cancel),
        .stock_avail(stock_avail),
        .red_inventario(red_inventario),
        .dispense(dispense),
        .credit(credit),
        .change_value(change_value),
        .change_valid(change_valid),
        .coin_reject(coin_reject),
        .sold_out(sold_out)
    );

    always #5 clk1 = ~clk1;

    // Three-unit inventory model: decrements on each reduce pulse.
    always @(posedge clk1) begin
        if (invLoad) invCount <= 2'd3;
        else if (red_inventario && invCount != 2'd0) invCount <= invCount - 2'd1;
    end

    assign stock_avail = useInv ? (invCount != 2'd0) : stockManual;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse1();
        coin1 = 1'b1; tick();
        coin1 = 1'b0; tick();
    endtask

    task automatic pulse2();
        coin2 = 1'b1; tick();
        coin2 = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset1 = 1'b1; coin1 = 1'b1; buy = 1'b1;
        tick(); tick();
        totalCount++; if (credit !== 3'd0) $display("FAIL reset_credit got %0d exp 0", credit); else passCount++;
        totalCount++; if (change_value !== 3'd0) $display("FAIL reset_change_value got %0d exp 0", change_value); else passCount++;
        totalCount++; if ({red_inventario, dispense, change_valid, coin_reject} !== 4'b0000)
            $display("FAIL reset_pulses got %b exp 0000", {red_inventario, dispense, change_valid, coin_reject}); else passCount++;
        totalCount++; if (sold_out !== 1'b0) $display("FAIL reset_sold_out got %b exp 0", sold_out); else passCount++;
        reset1 = 1'b0;
        tick(); tick();
        totalCount++; if (credit !== 3'd0) $display("FAIL held_release_credit got %0d exp 0", credit); else passCount++;
        totalCount++; if ({red_inventario, change_valid} !== 2'b00)
            $display("FAIL held_release_pulses got %b exp 00", {red_inventario, change_valid}); else passCount++;
        coin1 = 1'b0; buy = 1'b0;
        tick();
    endtask

    task automatic test_exact_sale();
        pulse2();
        totalCount++; if (credit !== 3'd2) $display("FAIL exact_credit2 got %0d exp 2", credit); else passCount++;
        pulse1();
        totalCount++; if (credit !== 3'd3) $display("FAIL exact_credit3 got %0d exp 3", credit); else passCount++;
        buy = 1'b1; tick();
        totalCount++; if ({red_inventario, dispense} !== 2'b11)
            $display("FAIL exact_vend got %b exp 11", {red_inventario, dispense}); else passCount++;
        buy = 1'b0; tick();
        totalCount++; if ({red_inventario, change_valid, change_value} !== 5'b01000)
            $display("FAIL exact_return got %b exp 01000", {red_inventario, change_valid, change_value}); else passCount++;
        tick();
        totalCount++; if ({change_valid, credit} !== 4'b0000)
            $display("FAIL exact_idle got %b exp 0000", {change_valid, credit}); else passCount++;
    endtask

    task automatic test_change();
        pulse2(); pulse2();
        totalCount++; if (credit !== 3'd4) $display("FAIL change_credit got %0d exp 4", credit); else passCount++;
        buy = 1'b1; tick();
        totalCount++; if (red_inventario !== 1'b1) $display("FAIL change_vend got %b exp 1", red_inventario); else passCount++;
        buy = 1'b0; tick();
        totalCount++; if ({red_inventario, change_valid, change_value} !== 5'b01001)
            $display("FAIL change_return got %b exp 01001", {red_inventario, change_valid, change_value}); else passCount++;
        tick();
    endtask

    task automatic test_sold_out();
        stockManual = 1'b0;
        #1;
        totalCount++; if (sold_out !== 1'b1) $display("FAIL soldout_flag got %b exp 1", sold_out); else passCount++;
        pulse2();
        buy = 1'b1; tick();
        totalCount++; if ({red_inventario, change_valid, change_value, sold_out} !== 6'b010101)
            $display("FAIL soldout_refund got %b exp 010101", {red_inventario, change_valid, change_value, sold_out}); else passCount++;
        buy = 1'b0; tick();
        totalCount++; if ({change_valid, credit, red_inventario} !== 5'b00000)
            $display("FAIL soldout_idle got %b exp 00000", {change_valid, credit, red_inventario}); else passCount++;
        stockManual = 1'b1;
        tick();
    endtask

    task automatic test_overflow();
        pulse2(); pulse2(); pulse2();
        totalCount++; if (credit !== 3'd6) $display("FAIL ovf_credit6 got %0d exp 6", credit); else passCount++;
        coin2 = 1'b1; tick();
        totalCount++; if ({coin_reject, credit} !== 4'b1110)
            $display("FAIL ovf_reject got %b exp 1110", {coin_reject, credit}); else passCount++;
        coin2 = 1'b0; tick();
        totalCount++; if (coin_reject !== 1'b0) $display("FAIL ovf_reject_clear got %b exp 0", coin_reject); else passCount++;
        pulse1();
        totalCount++; if (credit !== 3'd7) $display("FAIL ovf_credit7 got %0d exp 7", credit); else passCount++;
        cancel = 1'b1; tick();
        totalCount++; if ({change_valid, change_value} !== 4'b1111)
            $display("FAIL ovf_refund7 got %b exp 1111", {change_valid, change_value}); else passCount++;
        cancel = 1'b0; tick();
        pulse1();
        coin1 = 1'b1; coin2 = 1'b1; tick();
        totalCount++; if (credit !== 3'd4) $display("FAIL dual_coin got %0d exp 4", credit); else passCount++;
        coin1 = 1'b0; coin2 = 1'b0; tick();
        cancel = 1'b1; tick();
        totalCount++; if ({change_valid, change_value} !== 4'b1100)
            $display("FAIL dual_refund got %b exp 1100", {change_valid, change_value}); else passCount++;
        cancel = 1'b0; tick();
    endtask

    task automatic test_priority();
        pulse2(); pulse2(); pulse1();
        totalCount++; if (credit !== 3'd5) $display("FAIL prio_credit got %0d exp 5", credit); else passCount++;
        cancel = 1'b1; buy = 1'b1; tick();
        totalCount++; if ({red_inventario, change_valid, change_value} !== 5'b01101)
            $display("FAIL prio_refund got %b exp 01101", {red_inventario, change_valid, change_value}); else passCount++;
        cancel = 1'b0; buy = 1'b0; tick();
        totalCount++; if ({red_inventario, change_valid, credit} !== 5'b00000)
            $display("FAIL prio_idle got %b exp 00000", {red_inventario, change_valid, credit}); else passCount++;
    endtask

    task automatic test_reset_mid_sale();
        pulse2(); pulse1();
        buy = 1'b1; tick();
        totalCount++; if (red_inventario !== 1'b1) $display("FAIL abort_vend got %b exp 1", red_inventario); else passCount++;
        buy = 1'b0; reset1 = 1'b1; tick();
        totalCount++; if ({red_inventario, change_valid, credit} !== 5'b00000)
            $display("FAIL abort_reset got %b exp 00000", {red_inventario, change_valid, credit}); else passCount++;
        reset1 = 1'b0; tick();
        totalCount++; if ({red_inventario, change_valid, credit} !== 5'b00000)
            $display("FAIL abort_after got %b exp 00000", {red_inventario, change_valid, credit}); else passCount++;
    endtask

    task automatic test_back_to_back();
        invLoad = 1'b1; tick();
        invLoad = 1'b0; useInv = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            pulse2(); pulse1();
            buy = 1'b1; tick();
            totalCount++; if (red_inventario !== 1'b1) $display("FAIL chain_vend%0d got %b exp 1", i, red_inventario); else passCount++;
            buy = 1'b0; tick();
            totalCount++; if ({change_valid, change_value} !== 4'b1000)
                $display("FAIL chain_return%0d got %b exp 1000", i, {change_valid, change_value}); else passCount++;
            tick();
        end
        pulse2(); pulse1();
        totalCount++; if (sold_out !== 1'b1) $display("FAIL chain_empty got %b exp 1", sold_out); else passCount++;
        buy = 1'b1; tick();
        totalCount++; if ({red_inventario, change_valid, change_value} !== 5'b01011)
            $display("FAIL chain_refund got %b exp 01011", {red_inventario, change_valid, change_value}); else passCount++;
        buy = 1'b0; tick();
        useInv = 1'b0; tick();
    endtask

    task automatic test_timeout();
        bit seen;
        pulse2();
        seen = 1'b0;
`ifdef SALE_TIMEOUT_EN
        for (int i = 0; i < 40 && !seen; i++) begin
            if (change_valid) seen = 1'b1;
            else tick();
        end
        totalCount++; if (seen !== 1'b1) $display("FAIL timeout_seen got %b exp 1", seen); else passCount++;
        totalCount++; if (change_value !== 3'd2) $display("FAIL timeout_value got %0d exp 2", change_value); else passCount++;
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (change_valid) seen = 1'b1;
        end
        totalCount++; if (seen !== 1'b0) $display("FAIL no_timeout_refund got %b exp 0", seen); else passCount++;
        totalCount++; if (credit !== 3'd2) $display("FAIL no_timeout_credit got %0d exp 2", credit); else passCount++;
        cancel = 1'b1; tick();
        cancel = 1'b0; tick();
`endif
        totalCount++; if ({change_valid, credit} !== 4'b0000)
            $display("FAIL timeout_idle got %b exp 0000", {change_valid, credit}); else passCount++;
    endtask

    initial begin
        test_reset();
        test_exact_sale();
        test_change();
        test_sold_out();
        test_overflow();
        test_priority();
        test_reset_mid_sale();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
